// File: rtl/axi_ddr_mux_rr_if.sv
// Bundle of the master-side AXI buses and the single DDR controller port.
// The mux uses the slave view; the environment driving it uses the master view.
interface axi_ddr_mux_rr_if #(
  parameter int NUM_WM     = 4,
  parameter int NUM_RM     = 2,
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int SLV_AW     = 28
);
  localparam int SW = DATA_WIDTH / 8;

  logic [NUM_WM*ADDR_WIDTH-1:0] s_awaddr;
  logic [NUM_WM*8-1:0]          s_awlen;
  logic [NUM_WM-1:0]            s_awvalid;
  logic [NUM_WM-1:0]            s_awready;
  logic [NUM_WM*DATA_WIDTH-1:0] s_wdata;
  logic [NUM_WM*SW-1:0]         s_wstrb;
  logic [NUM_WM-1:0]            s_wvalid;
  logic [NUM_WM-1:0]            s_wlast;
  logic [NUM_WM-1:0]            s_wready;
  logic [NUM_RM*ADDR_WIDTH-1:0] s_araddr;
  logic [NUM_RM*8-1:0]          s_arlen;
  logic [NUM_RM-1:0]            s_arvalid;
  logic [NUM_RM-1:0]            s_arready;
  logic [DATA_WIDTH-1:0]        s_rdata;
  logic [NUM_RM-1:0]            s_rvalid;
  logic [NUM_RM-1:0]            s_rlast;

  logic [SLV_AW-1:0]            axi_awaddr;
  logic [3:0]                   axi_awlen;
  logic [3:0]                   axi_awuser_id;
  logic                         axi_awuser_ap;
  logic                         axi_awvalid;
  logic                         axi_awready;
  logic [DATA_WIDTH-1:0]        axi_wdata;
  logic [SW-1:0]                axi_wstrb;
  logic                         axi_wvalid;
  logic                         axi_wready;
  logic [SLV_AW-1:0]            axi_araddr;
  logic [3:0]                   axi_arlen;
  logic [3:0]                   axi_aruser_id;
  logic                         axi_aruser_ap;
  logic                         axi_arvalid;
  logic                         axi_arready;
  logic [DATA_WIDTH-1:0]        axi_rdata;
  logic [3:0]                   axi_rid;
  logic                         axi_rlast;
  logic                         axi_rvalid;

  modport slave (
    input  s_awaddr, s_awlen, s_awvalid,
    output s_awready,
    input  s_wdata, s_wstrb, s_wvalid, s_wlast,
    output s_wready,
    input  s_araddr, s_arlen, s_arvalid,
    output s_arready,
    output s_rdata, s_rvalid, s_rlast,
    output axi_awaddr, axi_awlen, axi_awuser_id,
    output axi_awuser_ap, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wvalid,
    input  axi_wready,
    output axi_araddr, axi_arlen, axi_aruser_id,
    output axi_aruser_ap, axi_arvalid,
    input  axi_arready,
    input  axi_rdata, axi_rid, axi_rlast, axi_rvalid
  );

  modport master (
    output s_awaddr, s_awlen, s_awvalid,
    input  s_awready,
    output s_wdata, s_wstrb, s_wvalid, s_wlast,
    input  s_wready,
    output s_araddr, s_arlen, s_arvalid,
    input  s_arready,
    input  s_rdata, s_rvalid, s_rlast,
    input  axi_awaddr, axi_awlen, axi_awuser_id,
    input  axi_awuser_ap, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wvalid,
    output axi_wready,
    input  axi_araddr, axi_arlen, axi_aruser_id,
    input  axi_aruser_ap, axi_arvalid,
    output axi_arready,
    output axi_rdata, axi_rid, axi_rlast, axi_rvalid
  );
endinterface

// File: rtl/axi_ddr_mux_rr.sv
// N-write / M-read round-robin AXI mux in front of the DDR controller port.
// Writes stay locked from AW handshake to last W beat; reads route back by rid.
module axi_ddr_mux_rr #(
  parameter int NUM_WM     = 4,
  parameter int NUM_RM     = 2,
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter int SLV_AW     = 28
) (
  input logic ACLK,
  input logic ARESET,
  axi_ddr_mux_rr_if.slave bus
);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int WIW = (NUM_WM > 1) ? $clog2(NUM_WM) : 1;
  localparam int RIW = (NUM_RM > 1) ? $clog2(NUM_RM) : 1;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} wst_e;
  typedef enum logic {R_IDLE, R_ADDR} rst_e;

  wst_e wst_q, wst_d;
  rst_e rst_q, rst_d;

  logic [WIW-1:0] wg_q, wg_d, wptr_q, wptr_d;
  logic [WIW-1:0] wsel, wi;
  logic           wfound;
  logic [RIW-1:0] rg_q, rg_d, rptr_q, rptr_d;
  logic [RIW-1:0] rsel, ri;
  logic           rfound;

  logic [SLV_AW-1:0]     awaddr_a [NUM_WM];
  logic [3:0]            awlen_a  [NUM_WM];
  logic [DATA_WIDTH-1:0] wdata_a  [NUM_WM];
  logic [SW-1:0]         wstrb_a  [NUM_WM];
  logic [SLV_AW-1:0]     araddr_a [NUM_RM];
  logic [3:0]            arlen_a  [NUM_RM];

  // Per-master views of the packed buses, already truncated to DDR widths
  for (genvar i = 0; i < NUM_WM; i++) begin : g_wsl
    assign awaddr_a[i] = bus.s_awaddr[i*ADDR_WIDTH +: SLV_AW];
    assign awlen_a[i]  = bus.s_awlen[i*8 +: 4];
    assign wdata_a[i]  = bus.s_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign wstrb_a[i]  = bus.s_wstrb[i*SW +: SW];
  end

  for (genvar i = 0; i < NUM_RM; i++) begin : g_rsl
    assign araddr_a[i] = bus.s_araddr[i*ADDR_WIDTH +: SLV_AW];
    assign arlen_a[i]  = bus.s_arlen[i*8 +: 4];
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wst_q  <= W_IDLE;
      wg_q   <= '0;
      wptr_q <= '0;
      rst_q  <= R_IDLE;
      rg_q   <= '0;
      rptr_q <= '0;
    end else begin
      wst_q  <= wst_d;
      wg_q   <= wg_d;
      wptr_q <= wptr_d;
      rst_q  <= rst_d;
      rg_q   <= rg_d;
      rptr_q <= rptr_d;
    end
  end

  // Scan downwards so the request closest to the pointer wins
  always_comb begin
    wsel   = wptr_q;
    wfound = 1'b0;
    wi     = '0;
    for (int k = NUM_WM - 1; k >= 0; k--) begin
      wi = WIW'((int'(wptr_q) + k) % NUM_WM);
      if (bus.s_awvalid[wi]) begin
        wfound = 1'b1;
        wsel   = wi;
      end
    end
  end

  always_comb begin
    rsel   = rptr_q;
    rfound = 1'b0;
    ri     = '0;
    for (int k = NUM_RM - 1; k >= 0; k--) begin
      ri = RIW'((int'(rptr_q) + k) % NUM_RM);
      if (bus.s_arvalid[ri]) begin
        rfound = 1'b1;
        rsel   = ri;
      end
    end
  end

  always_comb begin
    wst_d  = wst_q;
    wg_d   = wg_q;
    wptr_d = wptr_q;
    unique case (wst_q)
      W_IDLE: begin
        if (wfound) begin
          wg_d  = wsel;
          wst_d = W_ADDR;
        end
      end
      W_ADDR: begin
        if (bus.axi_awready) wst_d = W_DATA;
      end
      W_DATA: begin
        if (bus.s_wvalid[wg_q] && bus.axi_wready && bus.s_wlast[wg_q]) begin
          wst_d  = W_IDLE;
          wptr_d = (int'(wg_q) == NUM_WM - 1) ? '0 : wg_q + 1'b1;
        end
      end
      default: wst_d = W_IDLE;
    endcase
  end

  always_comb begin
    rst_d  = rst_q;
    rg_d   = rg_q;
    rptr_d = rptr_q;
    unique case (rst_q)
      R_IDLE: begin
        if (rfound) begin
          rg_d  = rsel;
          rst_d = R_ADDR;
        end
      end
      R_ADDR: begin
        if (bus.axi_arready) begin
          rst_d  = R_IDLE;
          rptr_d = (int'(rg_q) == NUM_RM - 1) ? '0 : rg_q + 1'b1;
        end
      end
      default: rst_d = R_IDLE;
    endcase
  end

  always_comb begin
    bus.s_awready     = '0;
    bus.s_wready      = '0;
    bus.axi_awvalid   = (wst_q == W_ADDR);
    bus.axi_awaddr    = awaddr_a[wg_q];
    bus.axi_awlen     = awlen_a[wg_q];
    bus.axi_awuser_id = 4'(wg_q);
    bus.axi_awuser_ap = 1'b1;
    bus.axi_wvalid    = 1'b0;
    bus.axi_wdata     = wdata_a[wg_q];
    bus.axi_wstrb     = wstrb_a[wg_q];
    if (wst_q == W_ADDR) bus.s_awready[wg_q] = bus.axi_awready;
    if (wst_q == W_DATA) begin
      bus.axi_wvalid     = bus.s_wvalid[wg_q];
      bus.s_wready[wg_q] = bus.axi_wready;
    end
  end

  always_comb begin
    bus.s_arready     = '0;
    bus.axi_arvalid   = (rst_q == R_ADDR);
    bus.axi_araddr    = araddr_a[rg_q];
    bus.axi_arlen     = arlen_a[rg_q];
    bus.axi_aruser_id = 4'(rg_q);
    bus.axi_aruser_ap = 1'b1;
    if (rst_q == R_ADDR) bus.s_arready[rg_q] = bus.axi_arready;
  end

  // Read return has no backpressure; ids beyond NUM_RM match nobody
  always_comb begin
    bus.s_rdata  = bus.axi_rdata;
    bus.s_rvalid = '0;
    bus.s_rlast  = '0;
    for (int i = 0; i < NUM_RM; i++) begin
      bus.s_rvalid[i] = !ARESET && bus.axi_rvalid
                        && (bus.axi_rid == 4'(i));
      bus.s_rlast[i]  = !ARESET && bus.axi_rvalid
                        && (bus.axi_rid == 4'(i)) && bus.axi_rlast;
    end
  end
endmodule
